// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ
// requesters. A requester may hold the grant with lock for up to MAX_LOCK
// consecutive cycles. Read data returns one cycle after the grant and is
// steered back to the requester that issued the read.
module dmem_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(MAX_LOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   prio_ptr;
    logic [IDX_W-1:0]   lock_owner;
    logic               lock_vld;
    logic [CNT_W-1:0]   lock_cnt;
    logic               lock_hit;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               keep_lock;
    logic [NUM_REQ-1:0] rd_vld_p1;
    logic [DATA_W-1:0]  rdata_p1;

    // Pick the winner: an unexpired lock owner first, else round-robin from prio_ptr.
    always_comb begin
        int idx;
        idx      = 0;
        win_vld  = 1'b0;
        win_idx  = '0;
        lock_hit = lock_vld && req[lock_owner] && (lock_cnt < LOCK_LIM);
        if (!rst) begin
            if (lock_hit) begin
                win_vld = 1'b1;
                win_idx = lock_owner;
            end else begin
                // Scan farthest-first so the closest pending requester overrides.
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    idx = (int'(prio_ptr) + k) % NUM_REQ;
                    if (req[idx]) begin
                        win_vld = 1'b1;
                        win_idx = IDX_W'(idx);
                    end
                end
            end
        end
    end

    // Drive the memory port and grant from the winner; all zero when idle.
    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_vld) begin
            gnt       = NUM_REQ'(1) << win_idx;
            mem_en    = 1'b1;
            mem_we    = we[win_idx];
            mem_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
            mem_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    // A lock is kept unless the owner has just used its last allowed grant.
    always_comb begin
        keep_lock = win_vld && lock[win_idx] &&
                    !(lock_vld && (lock_owner == win_idx) && (lock_cnt >= LOCK_LIM));
    end

    // Arbitration state: rotate priority past each winner and track the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr   <= '0;
            lock_owner <= '0;
            lock_vld   <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            if (win_vld) begin
                prio_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
            if (keep_lock) begin
                lock_vld   <= 1'b1;
                lock_owner <= win_idx;
                lock_cnt   <= (lock_vld && (lock_owner == win_idx)) ? lock_cnt + 1'b1
                                                                    : CNT_W'(1);
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    // Read return stage: remember who issued the read and keep the last data returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= '0;
            rdata_p1  <= '0;
        end else begin
            rd_vld_p1 <= (win_vld && !we[win_idx]) ? gnt : '0;
            if (|rd_vld_p1) begin
                rdata_p1 <= mem_rdata;
            end
        end
    end

    // Memory data arrives this cycle, so pass it through while a return is valid.
    always_comb begin
        rvalid = rst ? '0 : rd_vld_p1;
        if (rst) begin
            rdata = '0;
        end else if (|rd_vld_p1) begin
            rdata = mem_rdata;
        end else begin
            rdata = rdata_p1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of arbitration and memory.
module tb_dmem_arbiter;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int ML = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req, lock, we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;

    dmem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] shadow [32];
    int            m_ptr, m_owner, m_cnt, m_rd, m_win, last_win;
    logic [DW-1:0] m_rd_val, m_hold;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_winner();
        int w;
        w = -1;
        if (rst) return -1;
        if (m_owner >= 0 && req[m_owner] && m_cnt < ML) return m_owner;
        for (int off = 0; off < NR; off++) begin
            if (w < 0 && req[(m_ptr + off) % NR]) w = (m_ptr + off) % NR;
        end
        return w;
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, move past the edge.
    task automatic cycle(input int exp_gnt, input int exp_rv);
        logic [NR-1:0] e_gnt, e_rv;
        logic [DW-1:0] e_rdata;
        int a;
        #4;
        m_win = pick_winner();
        e_gnt = (m_win >= 0) ? NR'(1) << m_win : '0;
        check("gnt", gnt, e_gnt);
        if (exp_gnt >= 0) check("gnt_plan", gnt, exp_gnt);
        check("mem_en", mem_en, m_win >= 0);
        check("mem_we", mem_we, (m_win >= 0) ? we[m_win] : 1'b0);
        check("mem_addr", mem_addr, (m_win >= 0) ? addr[m_win*AW +: AW] : '0);
        check("mem_wdata", mem_wdata, (m_win >= 0) ? wdata[m_win*DW +: DW] : '0);
        e_rv = (!rst && m_rd >= 0) ? NR'(1) << m_rd : '0;
        check("rvalid", rvalid, e_rv);
        if (exp_rv >= 0) check("rvalid_plan", rvalid, exp_rv);
        e_rdata = rst ? '0 : ((m_rd >= 0) ? m_rd_val : m_hold);
        check("rdata", rdata, e_rdata);
        if (rst) begin
            m_ptr = 0; m_owner = -1; m_cnt = 0; m_rd = -1; m_hold = '0;
        end else begin
            if (m_rd >= 0) m_hold = m_rd_val;
            m_rd = -1;
            if (m_win >= 0) begin
                a = int'(addr[m_win*AW +: AW]);
                if (we[m_win]) shadow[a] = wdata[m_win*DW +: DW];
                else begin
                    m_rd = m_win;
                    m_rd_val = shadow[a];
                end
                m_ptr = (m_win + 1) % NR;
                if (lock[m_win] && !(m_win == m_owner && m_cnt >= ML)) begin
                    m_cnt = (m_win == m_owner) ? m_cnt + 1 : 1;
                    m_owner = m_win;
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end
        last_win = m_win;
        @(posedge clk); #1;
    endtask

    task automatic new_req(input int i);
        req[i] = 1'b1;
        we[i] = ($urandom_range(0, 2) == 0);
        addr[i*AW +: AW] = AW'($urandom_range(0, 31));
        wdata[i*DW +: DW] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hA500_0000 + i * 32'h0001_0101;
            shadow[i] = 32'hA500_0000 + i * 32'h0001_0101;
        end
        mem_rdata = '0;
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_rd = -1; m_hold = '0; m_rd_val = '0;
        last_win = -1;
        rst = 1'b1; req = 2'b11; lock = '0; we = '0; addr = '0; wdata = '0;
        @(posedge clk); #1;

        // Reset with requests pending, then idle.
        cycle(0, 0); cycle(0, 0);
        rst = 1'b0; req = 2'b00;
        cycle(0, 0); cycle(0, 0);

        // Write then read back from requester 0.
        req = 2'b01; we = 2'b01; addr[0 +: AW] = 5'd3; wdata[0 +: DW] = 32'hF;
        cycle(1, 0);
        we = 2'b00;
        cycle(1, 0);
        req = 2'b00;
        check("rd_ret_data", rdata, 32'hF);
        cycle(0, 1);

        // Round-robin between two readers.
        req = 2'b10; addr[AW +: AW] = 5'd5;
        cycle(2, 0);
        req = 2'b11;
        cycle(1, 2); cycle(2, 1); cycle(1, 2); cycle(2, 1);
        req = 2'b00;
        cycle(0, 2);

        // Lock bound: requester 1 locks for 6 cycles against a pending requester 0.
        req = 2'b01;
        cycle(1, 0);
        req = 2'b11; lock = 2'b10;
        cycle(2, 1); cycle(2, 2); cycle(2, 2); cycle(2, 2); cycle(1, 2); cycle(2, 1);
        req = 2'b00; lock = 2'b00;
        cycle(0, 2);

        // Lock dropped early with requester 0 waiting: no idle bubble.
        req = 2'b10; lock = 2'b10;
        cycle(2, 0);
        req = 2'b11; lock = 2'b00;
        cycle(2, 2); cycle(1, 2);
        req = 2'b00;
        cycle(0, 1);

        // Reset right after a granted read suppresses its return.
        req = 2'b01; we = 2'b00;
        cycle(1, 0);
        rst = 1'b1; req = 2'b00;
        cycle(0, 0);
        rst = 1'b0; req = 2'b11;
        cycle(1, 0);
        req = 2'b00;
        cycle(0, 1);

        // Randomized traffic obeying the hold-until-granted rule.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (req[i] && i == last_win) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 3) != 0) new_req(i);
                end else if (!req[i] && $urandom_range(0, 1) == 1) begin
                    new_req(i);
                end
                lock[i] = ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle(-1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32x32 data memory between NUM_REQ requesters, e.g. the core's LOAD/STR path and a debug/loader port.
- Round-robin arbitration with optional bounded locking for back-to-back accesses.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the requesters and the data memory array.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 5, memory word-address width (32 words).
- DATA_W, 32, data word width.
- MAX_LOCK, 4, maximum consecutive grants one requester may hold via lock (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request.
- lock  in  NUM_REQ  per-requester request to keep the grant next cycle.
- we  in  NUM_REQ  per-requester write enable (1=write, 0=read).
- addr  in  NUM_REQ*ADDR_W  requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  requester i uses bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rvalid  out  NUM_REQ  registered; read data valid for requester i.
- rdata  out  DATA_W  read data, shared by all requesters, qualified by rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1 and mem_we=0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - prio_ptr=0, lock_owner=none, lock_cnt=0.
  - rvalid=0, rdata=0, internal rd_owner pipeline cleared.
  - While rst=1: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Requests in that cycle are dropped.
- Arbitration (combinational, every cycle):
  - If a lock is held and its owner has req=1 and lock_cnt<MAX_LOCK, the owner wins.
  - Otherwise the winner is the first requester with req=1, scanning from prio_ptr upward and wrapping modulo NUM_REQ.
  - No req set: gnt=0 and mem_en=0.
- Memory drive: mem_en=|gnt. mem_we, mem_addr and mem_wdata are muxed from the winner. When there is no winner, mem_addr and mem_wdata are 0.
- Grant acceptance: a granted access completes in that cycle. A requester whose gnt=0 must hold req, we, addr and wdata until it is granted.
- Read return: for a granted read (we=0), rvalid[winner]=1 and rdata=mem_rdata in the next cycle. Latency is 1. Reads may issue back-to-back with throughput 1 per cycle. Writes never produce rvalid.
- rdata holds its last value when no rvalid is set.
- Pointer update on every grant to requester w: prio_ptr <= (w+1) mod NUM_REQ.
- Lock sequencing:
  - Granted w with lock[w]=1: lock_owner<=w, lock_cnt<=lock_cnt+1. When w was not already the owner, lock_cnt<=1 instead.
  - Granted w with lock[w]=0, or owner req=0: lock released, lock_cnt<=0.
  - lock_cnt reaches MAX_LOCK: the owner is not favoured in the next arbitration and round-robin from prio_ptr applies. If no other requester is pending, the owner wins normally. The lock is then released.
- Simultaneous events: a lock released and a new request in the same cycle are arbitrated round-robin in that cycle, with no idle bubble. A read issued by one requester and a read issued by another in the next cycle return in order, one cycle each.
- Reset mid-operation: an outstanding read issued in the cycle before rst does not return an rvalid.
- Wrap-around:
  - prio_ptr wraps from NUM_REQ-1 to 0.
  - lock_cnt saturates at MAX_LOCK and never wraps.

Test Plan:
- Idle and reset: hold rst=1 for 2 cycles with req=2'b11. Required: gnt=0, mem_en=0, rvalid=0, rdata=0. Release rst with req=0: outputs stay 0.
- Single read and write:
  - Requester 0 writes addr 3, wdata 0xF. Required: gnt=01, mem_we=1, mem_addr=3 in the same cycle.
  - Next cycle requester 0 reads addr 3, with the memory model returning 0xF. Required: one cycle later rvalid=01 and rdata=0xF.
- Round-robin fairness: req=11 held for 4 cycles, lock=0, all reads. Required: gnt sequence 01,10,01,10, and rvalid sequence delayed one cycle with the matching owner each cycle.
- Lock bound with MAX_LOCK=4: requester 1 holds req and lock for 6 cycles, requester 0 holds req. Required: gnt=10 for 4 cycles, then 01, then 10.
- Lock released early: requester 1 locks for 2 cycles, then drops lock while requester 0 is pending. Required: gnt=10,10,01 with no idle cycle.
- Reset mid-read: requester 0 read granted in cycle N, rst=1 in cycle N+1. Required: rvalid stays 0 in cycle N+1, and prio_ptr=0 afterwards, so req=11 grants 01 first.
